// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port round-robin arbiter in front of a single-port RAM with fill sweep
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0/1, we0/1               per-requester access request and write flag
//   addr0/1, wdata0/1           per-requester word address and write data
//   gnt0/1                      combinational grant (request accepted this cycle)
//   rvalid0/1, rdata            read return, 2 cycles after the read grant
//   clear_req, busy             start a fill sweep / sweep in progress
//   ram_addra, ram_cea, ram_wea, ram_dia, ram_ocea, ram_rsta, ram_doa
//                               single-port RAM with 2-cycle registered read

module ram_arbiter #(
    parameter bit         INIT_ON_RESET = 1'b1,
    parameter logic [1:0] INIT_VALUE    = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [1:0] wdata0,
    input  logic [1:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [1:0] rdata,
    input  logic       clear_req,
    output logic       busy,
    output logic [7:0] ram_addra,
    output logic       ram_cea,
    output logic       ram_wea,
    output logic [1:0] ram_dia,
    output logic       ram_ocea,
    output logic       ram_rsta,
    input  logic [1:0] ram_doa
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] sweep_cnt;
    logic       last_gnt;      // 1 = port 1 was granted most recently
    logic       pipe_v1;
    logic       pipe_id1;
    logic       pipe_v2;
    logic       pipe_id2;

    logic       in_init;
    logic       in_run;
    logic       pick1;
    logic       rd_gnt;

    // Outputs must sit at their reset values while rst_n is low, even though
    // the state register already holds the post-reset state, so the state
    // decode is qualified with rst_n.
    assign in_init = rst_n && (state == ST_INIT);
    assign in_run  = rst_n && (state == ST_RUN);
    assign busy    = in_init;

    // Port 1 wins when it is alone, or when both request and port 0 was
    // the most recent winner.
    assign pick1 = req1 && (!req0 || !last_gnt);
    assign gnt1  = in_run && pick1;
    assign gnt0  = in_run && req0 && !pick1;

    assign rd_gnt = (gnt0 && !we0) || (gnt1 && !we1);

    assign ram_ocea = 1'b1;
    assign ram_rsta = 1'b0;

    always_comb begin
        ram_cea   = 1'b0;
        ram_wea   = 1'b0;
        ram_addra = 8'h00;
        ram_dia   = 2'b00;
        if (in_init) begin
            ram_cea   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = sweep_cnt;
            ram_dia   = INIT_VALUE;
        end else if (gnt1) begin
            ram_cea   = 1'b1;
            ram_wea   = we1;
            ram_addra = addr1;
            ram_dia   = wdata1;
        end else if (gnt0) begin
            ram_cea   = 1'b1;
            ram_wea   = we0;
            ram_addra = addr0;
            ram_dia   = wdata0;
        end
    end

    // The read-return pipeline mirrors the RAM's 2-cycle latency and keeps
    // shifting in both states, so reads issued just before a sweep still
    // return their data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            sweep_cnt <= 8'h00;
            last_gnt  <= 1'b1;
            pipe_v1   <= 1'b0;
            pipe_id1  <= 1'b0;
            pipe_v2   <= 1'b0;
            pipe_id2  <= 1'b0;
        end else begin
            pipe_v1  <= rd_gnt;
            pipe_id1 <= gnt1;
            pipe_v2  <= pipe_v1;
            pipe_id2 <= pipe_id1;

            if (gnt0 || gnt1) begin
                last_gnt <= gnt1;
            end

            case (state)
                ST_INIT: begin
                    sweep_cnt <= sweep_cnt + 8'd1;
                    if (sweep_cnt == 8'hff) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state     <= ST_INIT;
                        sweep_cnt <= 8'h00;
                    end
                end
            endcase
        end
    end

    assign rvalid0 = pipe_v2 && !pipe_id2;
    assign rvalid1 = pipe_v2 && pipe_id2;
    assign rdata   = ram_doa;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter

`timescale 1ns/1ps

module tb_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1;
    logic [1:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [1:0] rdata;
    logic       clear_req, busy;
    logic [7:0] ram_addra;
    logic       ram_cea, ram_wea, ram_ocea, ram_rsta;
    logic [1:0] ram_dia, ram_doa;

    int n_tests;
    int n_fail;

    ram_arbiter #(
        .INIT_ON_RESET(1'b1),
        .INIT_VALUE   (2'b00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .clear_req(clear_req),
        .busy     (busy),
        .ram_addra(ram_addra),
        .ram_cea  (ram_cea),
        .ram_wea  (ram_wea),
        .ram_dia  (ram_dia),
        .ram_ocea (ram_ocea),
        .ram_rsta (ram_rsta),
        .ram_doa  (ram_doa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, then output register -> data 2 cycles after address.
    logic [1:0] mem [256];
    logic [1:0] ram_r1;
    always @(posedge clk) begin
        if (ram_cea) begin
            if (ram_wea) mem[ram_addra] <= ram_dia;
            else         ram_r1 <= mem[ram_addra];
        end
        if (ram_rsta)      ram_doa <= 2'b00;
        else if (ram_ocea) ram_doa <= ram_r1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks a sweep from index first to 255; starts in the cycle whose
    // address should be first and returns at the start of the first RUN cycle.
    task automatic sweep(input string tag, input int first, input int pulse_at);
        logic bad;
        bad = 1'b0;
        for (int i = first; i < 256; i++) begin
            clear_req = (i == pulse_at);
            @(negedge clk);
            check({tag, "_addr"}, ram_addra, i);
            if (!busy || !ram_cea || !ram_wea || ram_dia !== 2'b00 || gnt0 || gnt1 ||
                rvalid0 || rvalid1)
                bad = 1'b1;
            next_cycle();
        end
        clear_req = 1'b0;
        check({tag, "_ctl"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h33; wdata0 = 2'b11;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05; wdata1 = 2'b00;
        clear_req = 1'b0;

        // Reset state, with requests active.
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_rvalid", {rvalid0, rvalid1}, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_ce_we", {ram_cea, ram_wea}, 0);
        check("ram_ties", {ram_ocea, ram_rsta}, 2'b10);

        // Release reset: 256-cycle sweep while req1 is held.
        next_cycle();
        req0  = 1'b0;
        rst_n = 1'b1;
        sweep("init", 0, -1);

        // First RUN cycle grants the held req1 (read of 0x05 -> 00).
        @(negedge clk);
        check("run_busy", busy, 0);
        check("first_gnt1", gnt1, 1);
        next_cycle();
        req1 = 1'b0;
        @(negedge clk);
        check("r05_early", {rvalid0, rvalid1}, 0);
        next_cycle();
        @(negedge clk);
        check("r05_rvalid", {rvalid0, rvalid1}, 2'b01);
        check("r05_data", rdata, 2'b00);

        // Write 0x10=11 in W, read it in W+1, data at W+3.
        next_cycle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 2'b11;
        @(negedge clk);
        check("wr_gnt0", gnt0, 1);
        check("wr_ram", {ram_cea, ram_wea, ram_addra, ram_dia}, {2'b11, 8'h10, 2'b11});
        next_cycle();
        we0 = 1'b0;
        @(negedge clk);
        check("rd_gnt0", gnt0, 1);
        next_cycle();
        req0 = 1'b0;
        @(negedge clk);
        check("rd_idle_ce", ram_cea, 0);
        check("rd_w2", {rvalid0, rvalid1}, 0);
        next_cycle();
        @(negedge clk);
        check("rd_w3_valid", {rvalid0, rvalid1}, 2'b10);
        check("rd_w3_data", rdata, 2'b11);

        // Setup 0x01=01 via port 0, 0x02=10 via port 1 (last grant -> port 1).
        next_cycle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 2'b01;
        @(negedge clk);
        check("setup_gnt0", gnt0, 1);
        next_cycle();
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h02; wdata1 = 2'b10;
        @(negedge clk);
        check("setup_gnt1", gnt1, 1);

        // Both read for 6 cycles: alternate 0,1,... and returns follow 2 later.
        next_cycle();
        we0 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(negedge clk);
            if (k < 6)
                check($sformatf("rr_gnt_%0d", k), {gnt0, gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k >= 2) begin
                check($sformatf("rr_rv_%0d", k), {rvalid0, rvalid1}, (k % 2 == 0) ? 2'b10 : 2'b01);
                check($sformatf("rr_data_%0d", k), rdata, (k % 2 == 0) ? 2'b01 : 2'b10);
            end else begin
                check($sformatf("rr_rv_%0d", k), {rvalid0, rvalid1}, 0);
            end
            next_cycle();
        end

        // Port 1 read of 0x10 with clear_req in the same cycle H.
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        clear_req = 1'b1;
        @(negedge clk);
        check("clr_gnt1", gnt1, 1);
        check("clr_busy_h", busy, 0);
        next_cycle();
        req1 = 1'b0;
        clear_req = 1'b0;
        @(negedge clk);
        check("clr_h1_addr", {busy, ram_wea, ram_addra}, {2'b11, 8'h00});
        next_cycle();
        @(negedge clk);
        check("clr_h2_valid", {rvalid0, rvalid1}, 2'b01);
        check("clr_h2_data", rdata, 2'b11);
        next_cycle();
        // Mid-sweep clear_req pulse must not restart the sweep.
        sweep("clr", 2, 50);

        @(negedge clk);
        check("clr_done_busy", busy, 0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        @(negedge clk);
        next_cycle();
        req0 = 1'b0;
        next_cycle();
        @(negedge clk);
        check("post_clr_valid", rvalid0, 1);
        check("post_clr_data", rdata, 2'b00);

        // Reset pulse at sweep address 100, then full restart from 0.
        next_cycle();
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) next_cycle();
        @(negedge clk);
        check("mid_addr100", ram_addra, 100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", {busy, ram_cea, ram_wea, gnt0, gnt1, rvalid0, rvalid1}, 0);
        next_cycle();
        rst_n = 1'b1;
        sweep("restart", 0, -1);

        // Read in flight when reset hits is discarded.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        @(negedge clk);
        check("flight_gnt0", gnt0, 1);
        next_cycle();
        req0  = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("flight_drop_a", {rvalid0, rvalid1}, 0);
        next_cycle();
        @(negedge clk);
        check("flight_drop_b", {rvalid0, rvalid1}, 0);
        check("flight_sweep", {busy, ram_addra}, {1'b1, 8'h01});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter INIT_ON_RESET, default 1, meaning: 1 runs the zero-fill sweep after reset, 0 enters RUN directly.
REQ-002 SHALL have parameter INIT_VALUE, default 2'b00, meaning: the data written to every address during a sweep.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  single clock for all logic; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request from requester 0 / 1.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  8  word address.
- wdata0, wdata1  in  2  write data.
- gnt0, gnt1  out  1  request accepted this cycle.
- rvalid0, rvalid1  out  1  read data valid for requester 0 / 1.
- rdata  out  2  shared read data.
- clear_req  in  1  one-cycle pulse that starts a fill sweep.
- busy  out  1  sweep in progress.
- ram_addra  out  8  RAM address.
- ram_cea  out  1  RAM chip enable.
- ram_wea  out  1  RAM write enable.
- ram_dia  out  2  RAM write data.
- ram_ocea  out  1  RAM output-register enable.
- ram_rsta  out  1  RAM output reset.
- ram_doa  in  2  RAM output, registered, 2-cycle read latency.

Function
REQ-004 SHALL implement two states, INIT and RUN.
REQ-005 SHALL enter INIT when reset is released if INIT_ON_RESET=1, otherwise RUN.
REQ-006 SHALL enter INIT from RUN on the cycle after clear_req=1.
REQ-007 SHALL ignore clear_req while in INIT.
REQ-008 SHALL, in INIT, drive each cycle: ram_cea=1, ram_wea=1, ram_dia=INIT_VALUE, ram_addra=sweep counter.
REQ-009 SHALL start the sweep counter at 0, increment it by 1 each cycle, and move to RUN after address 255 is written, so INIT lasts exactly 256 cycles.
REQ-010 SHALL assert busy exactly while in INIT.
REQ-011 SHALL hold gnt0=gnt1=0 in INIT; requests stay pending and are not dropped.
REQ-012 SHALL, in RUN, grant at most one requester per cycle.
- Grant is combinational: gntN = reqN AND selected AND (state==RUN).
- A requester holds req, we, addr and wdata stable until it sees gnt.
REQ-013 SHALL arbitrate round-robin.
- Single request: granted immediately.
- Both requesting: grant the one not granted most recently.
- Last-grant pointer resets to "1", so port 0 wins first.
- Pointer updates only on a grant.
REQ-014 SHALL, in a grant cycle, drive ram_cea=1, ram_wea=weN, ram_addra=addrN, ram_dia=wdataN; ram_cea=0 when there is no grant and the state is not INIT.
REQ-015 SHALL tie ram_ocea=1 and ram_rsta=0.
REQ-016 SHALL give writes no response; gnt completes the write.
REQ-017 SHALL return read data through a 2-stage valid/id pipeline.
- A read granted in cycle H gives rvalidN=1 in cycle H+2 only, with rdata=ram_doa.
- Back-to-back reads give back-to-back rvalid pulses in grant order.
REQ-018 SHALL make a read granted the cycle after a write to the same address return the new data.
REQ-019 SHALL keep the read pipeline running across a RUN to INIT transition: reads granted before clear_req still return their pre-sweep data at H+2.
REQ-020 SHALL never assert rvalid0 and rvalid1 in the same cycle.

Reset
REQ-021 SHALL, while rst_n=0, force:
- gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=ram_doa (don't-care).
- ram_cea=0, ram_wea=0.
- busy=0, pipeline cleared, pointer=1, sweep counter=0.
REQ-022 SHALL treat reset asserted mid-sweep or with reads in flight as a full restart: pending reads are discarded, and the sweep restarts at address 0 per REQ-005.

Verification
REQ-023 Reset release with INIT_ON_RESET=1 -> busy=1 for exactly 256 cycles, ram_wea=1 with ram_addra 0..255 in order and ram_dia=2'b00; then busy=0 and gnt is possible on the next cycle.
REQ-024 After INIT, port 0 writes addr 0x10 data 2'b11 (cycle W), then reads 0x10 in cycle W+1 -> rvalid0=1 in cycle W+3 with rdata=2'b11, and rvalid1 stays 0.
REQ-025 Both ports hold read requests to addr 0x01 / 0x02 (data 2'b01 / 2'b10) for 6 cycles -> grants 0,1,0,1,0,1 and rvalid pattern 0,1,0,1,0,1 two cycles later with matching data.
REQ-026 Port 1 read of addr 0x10 (value 2'b11) granted in cycle H, clear_req in cycle H -> rvalid1 at H+2 with 2'b11; busy for 256 cycles; a later read of 0x10 returns 2'b00.
REQ-027 rst_n pulled low at sweep address 100 for 1 cycle -> outputs at reset values immediately, and the sweep restarts at address 0 after release.
REQ-028 req1 held during INIT -> gnt1=0 throughout, then gnt1=1 in the first RUN cycle.
